phi_seq_ctrl: RTL and testbench

PHI_SEQ_CTRL -- requirements
Module: phi_seq_ctrl

---
 rtl/phi_seq_ctrl_pkg.sv | 29 ++
 rtl/phi_seq_ctrl_if.sv | 26 ++
 rtl/phi_seq_ctrl_cnt.sv | 27 ++
 rtl/phi_unit_dual.sv | 29 ++
 rtl/phi_seq_ctrl.sv | 117 +++++++++++
 tb/tb_phi_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 6 files changed

// File: rtl/phi_seq_ctrl_pkg.sv
// Shared types and constants for the phi sequencing controller and phi unit.
// phi_fwd/phi_bwd are the forward tweak update and its exact inverse.
package phi_seq_ctrl_pkg;

    localparam int NVAL_DEF = 7;
    localparam int CW_DEF   = 3;
    localparam int PHI_W    = 8;

    localparam logic [PHI_W-1:0] PHI_RC = 8'h1D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WIND  = 2'd1,
        SERVE = 2'd2,
        FIN   = 2'd3
    } state_t;

    function automatic logic [PHI_W-1:0] phi_fwd(input logic [PHI_W-1:0] x);
        return {x[PHI_W-2:0], x[PHI_W-1]} ^ PHI_RC;
    endfunction

    // Undo the constant first, then rotate back.
    function automatic logic [PHI_W-1:0] phi_bwd(input logic [PHI_W-1:0] y);
        logic [PHI_W-1:0] t;
        t = y ^ PHI_RC;
        return {t[0], t[PHI_W-1:1]};
    endfunction

endpackage

// File: rtl/phi_seq_ctrl_if.sv
// Handshake bundle between the run requester / phi consumer and the controller.
interface phi_seq_ctrl_if;

    logic start;
    logic decrypt;
    logic take;
    logic abort;
    logic ready;
    logic phi_valid;
    logic phi_last;
    logic done;
    logic phi_ld;
    logic phi_en;
    logic phi_inv;

    modport master (
        output start, decrypt, take, abort,
        input  ready, phi_valid, phi_last, done, phi_ld, phi_en, phi_inv
    );

    modport slave (
        input  start, decrypt, take, abort,
        output ready, phi_valid, phi_last, done, phi_ld, phi_en, phi_inv
    );

endinterface

// File: rtl/phi_seq_ctrl_cnt.sv
// Saturating phi-index counter: load-to-one, count up, count down.
module phi_seq_ctrl_cnt #(
    parameter int NVAL = 7,
    parameter int CW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load1,
    input  logic          up,
    input  logic          dn,
    output logic [CW-1:0] cnt
);

    // Bounded at both ends so a stray step can never wrap the index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= CW'(1);
        end else if (up && (cnt < CW'(NVAL))) begin
            cnt <= cnt + 1'b1;
        end else if (dn && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/phi_unit_dual.sv
// Phi register with forward/inverse update; phi_ld muxes phi_in onto both the
// output and the update path so the load cycle already presents phi0.
module phi_unit_dual
    import phi_seq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [PHI_W-1:0] phi_in,
    input  logic             phi_ld,
    input  logic             phi_en,
    input  logic             phi_inv,
    output logic [PHI_W-1:0] phi_out
);

    logic [PHI_W-1:0] phi_q;
    logic [PHI_W-1:0] src;

    assign src     = phi_ld ? phi_in : phi_q;
    assign phi_out = src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phi_q <= '0;
        end else if (phi_en) begin
            phi_q <= phi_inv ? phi_bwd(src) : phi_fwd(src);
        end
    end

endmodule

// File: rtl/phi_seq_ctrl.sv
// Phi sequencing controller: encrypt walks phi0..phiN-1 forward; decrypt winds
// the register forward to phiN-1, then steps it back one value per take.
module phi_seq_ctrl
    import phi_seq_ctrl_pkg::*;
#(
    parameter int NVAL = NVAL_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    phi_seq_ctrl_if.slave bus
);

    state_t        state, state_nxt;
    logic          decrypt_r;
    logic [CW-1:0] cnt;
    logic          cnt_load, cnt_up, cnt_dn;
    logic          start_ok, at_last, wind_end;

    // cnt is the index of the phi value the register currently holds.
    assign start_ok = bus.start & ~rst;
    assign at_last  = decrypt_r ? (cnt == '0) : (cnt == CW'(NVAL - 1));
    assign wind_end = (cnt == CW'(NVAL - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            decrypt_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && start_ok) begin
                decrypt_r <= bus.decrypt;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.ready     = 1'b0;
        bus.phi_valid = 1'b0;
        bus.phi_last  = 1'b0;
        bus.done      = 1'b0;
        bus.phi_ld    = 1'b0;
        bus.phi_en    = 1'b0;
        bus.phi_inv   = 1'b0;
        cnt_load      = 1'b0;
        cnt_up        = 1'b0;
        cnt_dn        = 1'b0;
        unique case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (start_ok) begin
                    bus.phi_ld = 1'b1;
                    bus.phi_en = 1'b1;
                    cnt_load   = 1'b1;
                    // Encrypt hands phi0 over straight from phi_in this cycle.
                    if (bus.decrypt) begin
                        state_nxt = (NVAL == 2) ? SERVE : WIND;
                    end else begin
                        bus.phi_valid = 1'b1;
                        state_nxt     = SERVE;
                    end
                end
            end
            WIND: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else begin
                    bus.phi_en = 1'b1;
                    cnt_up     = 1'b1;
                    if (wind_end) state_nxt = SERVE;
                end
            end
            SERVE: begin
                bus.phi_inv = decrypt_r;
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else begin
                    bus.phi_valid = 1'b1;
                    bus.phi_last  = at_last;
                    if (bus.take) begin
                        // The final take leaves the register where it is.
                        if (at_last) begin
                            state_nxt = FIN;
                        end else begin
                            bus.phi_en = 1'b1;
                            cnt_up     = ~decrypt_r;
                            cnt_dn     = decrypt_r;
                        end
                    end
                end
            end
            FIN: begin
                bus.done  = ~bus.abort;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    phi_seq_ctrl_cnt #(
        .NVAL (NVAL),
        .CW   (CW)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .load1 (cnt_load),
        .up    (cnt_up),
        .dn    (cnt_dn),
        .cnt   (cnt)
    );

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt <= CW'(NVAL));
    a_ld_idle:   assert property (@(posedge clk) disable iff (rst) bus.phi_ld |-> (state == IDLE));
    a_done_fin:  assert property (@(posedge clk) disable iff (rst) bus.done |-> ((state == FIN) && !bus.phi_valid));

endmodule

// File: tb/tb_phi_seq_ctrl.sv
// Scoreboard bench for phi_seq_ctrl driving phi_unit_dual: stimulus queues the
// expected deliveries/done/idle events with their cycle; a monitor pops and compares.
module tb_phi_seq_ctrl;
    import phi_seq_ctrl_pkg::*;

    typedef enum int {EV_DELIV = 0, EV_DONE = 1, EV_IDLE = 2} ev_t;

    typedef struct {
        ev_t        kind;
        int         cyc;
        logic [7:0] data;
        logic       last;
        bit         chk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] phi_in = 8'h00;
    logic [7:0] phi_out;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         tb_end = 1'b0;
    logic       ready_prev = 1'b1;
    exp_t       exp_q[$];

    // Hand-computed phi chains: phi(k+1) = rotl1(phi(k)) ^ 8'h1D
    logic [7:0] pa [7] = '{8'h01, 8'h1F, 8'h23, 8'h5B, 8'hAB, 8'h4A, 8'h89};
    logic [7:0] pb [7] = '{8'h80, 8'h1C, 8'h25, 8'h57, 8'hB3, 8'h7A, 8'hE9};
    // Delivery offsets for take pattern 1,0,0,1 starting at t1
    int         gap_off [7] = '{0, 1, 4, 5, 8, 9, 12};

    phi_seq_ctrl_if bus ();

    phi_seq_ctrl #(.NVAL(7), .CW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    phi_unit_dual u_phi (
        .clk     (clk),
        .rst     (rst),
        .phi_in  (phi_in),
        .phi_ld  (bus.phi_ld),
        .phi_en  (bus.phi_en),
        .phi_inv (bus.phi_inv),
        .phi_out (phi_out)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1);
    end

    function automatic logic [7:0] ph(input bit b, input int k);
        return b ? pb[k] : pa[k];
    endfunction

    task automatic push(input ev_t k, input int c, input logic [7:0] d, input logic l, input bit chk);
        exp_t e;
        e.kind = k; e.cyc = c; e.data = d; e.last = l; e.chk = chk;
        exp_q.push_back(e);
    endtask

    task automatic take_ev(input ev_t k, input string nm);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected event cyc=%0d data=%h last=%b", nm, cyc, phi_out, bus.phi_last);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.cyc != cyc ||
            (k == EV_DELIV && (phi_out !== e.data || bus.phi_last !== e.last)) ||
            (k == EV_IDLE && e.chk && phi_out !== e.data)) begin
            failures++;
            $display("FAIL %s got kind=%0d cyc=%0d data=%h last=%b want kind=%0d cyc=%0d data=%h last=%b",
                     nm, k, cyc, phi_out, bus.phi_last, e.kind, e.cyc, e.data, e.last);
        end
    endtask

    // Monitor
    initial forever begin
        @(negedge clk);
        if (rst) begin
            checks++;
            if (!(bus.ready === 1'b1 && bus.phi_valid === 1'b0 && bus.phi_last === 1'b0 &&
                  bus.done === 1'b0 && bus.phi_ld === 1'b0 && bus.phi_en === 1'b0 &&
                  bus.phi_inv === 1'b0 && phi_out === 8'h00)) begin
                failures++;
                $display("FAIL rst_outs cyc=%0d got rdy=%b v=%b l=%b d=%b ld=%b en=%b inv=%b phi=%h want rdy=1 others 0",
                         cyc, bus.ready, bus.phi_valid, bus.phi_last, bus.done, bus.phi_ld,
                         bus.phi_en, bus.phi_inv, phi_out);
            end
        end
        checks++;
        if (bus.phi_ld === 1'b1 && bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL ld_only_idle cyc=%0d got ld=1 ready=%b want ready=1", cyc, bus.ready);
        end
        if (bus.ready === 1'b1 && ready_prev !== 1'b1) take_ev(EV_IDLE, "idle");
        if (bus.done === 1'b1) take_ev(EV_DONE, "done");
        if (bus.phi_valid === 1'b1 && (bus.take === 1'b1 || bus.phi_ld === 1'b1)) take_ev(EV_DELIV, "deliv");
        ready_prev = bus.ready;
        if (tb_end) begin
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL leftover got=%0d pending events want=0", exp_q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in the current cycle; returns in the FIN cycle with take low.
    task automatic enc_run(input bit b, input bit hold, input bit idle_chk);
        int t0;
        t0 = cyc;
        for (int k = 0; k < 7; k++) push(EV_DELIV, t0 + k, ph(b, k), (k == 6), 1'b0);
        push(EV_DONE, t0 + 7, 8'h00, 1'b0, 1'b0);
        push(EV_IDLE, t0 + 8, ph(b, 6), 1'b0, idle_chk);
        bus.start = 1'b1; bus.decrypt = 1'b0; bus.take = 1'b1; phi_in = ph(b, 0);
        tick();
        if (!hold) bus.start = 1'b0;
        phi_in = 8'hFF;
        repeat (6) tick();
        bus.take = 1'b0;
    endtask

    task automatic dec_run(input bit b);
        int t0;
        t0 = cyc;
        for (int j = 0; j < 7; j++) push(EV_DELIV, t0 + 6 + j, ph(b, 6 - j), (j == 6), 1'b0);
        push(EV_DONE, t0 + 13, 8'h00, 1'b0, 1'b0);
        push(EV_IDLE, t0 + 14, ph(b, 0), 1'b0, 1'b1);
        bus.start = 1'b1; bus.decrypt = 1'b1; bus.take = 1'b1; phi_in = ph(b, 0);
        tick();
        bus.start = 1'b0; bus.decrypt = 1'b0;
        repeat (12) tick();
        bus.take = 1'b0;
    endtask

    initial begin
        int t0;
        bus.start = 1'b0; bus.decrypt = 1'b0; bus.take = 1'b0; bus.abort = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Encrypt, take every cycle
        enc_run(1'b0, 1'b0, 1'b1);
        repeat (3) tick();

        // Decrypt, take held high
        dec_run(1'b0);
        repeat (3) tick();

        // Encrypt, gapped takes
        t0 = cyc;
        for (int k = 0; k < 7; k++) push(EV_DELIV, t0 + gap_off[k], pa[k], (k == 6), 1'b0);
        push(EV_DONE, t0 + 13, 8'h00, 1'b0, 1'b0);
        push(EV_IDLE, t0 + 14, pa[6], 1'b0, 1'b1);
        bus.start = 1'b1; bus.decrypt = 1'b0; bus.take = 1'b0; phi_in = pa[0];
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.take = (i % 4 == 0) || (i % 4 == 3);
            tick();
        end
        bus.take = 1'b0;
        repeat (3) tick();

        // Abort with take on the 3rd SERVE cycle: register must hold phi3
        t0 = cyc;
        push(EV_DELIV, t0,     pa[0], 1'b0, 1'b0);
        push(EV_DELIV, t0 + 1, pa[1], 1'b0, 1'b0);
        push(EV_DELIV, t0 + 2, pa[2], 1'b0, 1'b0);
        push(EV_IDLE,  t0 + 4, pa[3], 1'b0, 1'b1);
        bus.start = 1'b1; bus.decrypt = 1'b0; bus.take = 1'b1; phi_in = pa[0];
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0; bus.take = 1'b0;
        tick();
        enc_run(1'b0, 1'b0, 1'b1);
        repeat (3) tick();

        // Abort during WIND, restart in the very next (IDLE) cycle
        t0 = cyc;
        push(EV_IDLE, t0 + 3, 8'h00, 1'b0, 1'b0);
        bus.start = 1'b1; bus.decrypt = 1'b1; bus.take = 1'b0; phi_in = pa[0];
        tick();
        bus.start = 1'b0; bus.decrypt = 1'b0;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        enc_run(1'b1, 1'b0, 1'b1);
        repeat (3) tick();

        // start held through a whole run: exactly one run
        enc_run(1'b0, 1'b1, 1'b1);
        tick();
        bus.start = 1'b0;
        repeat (2) tick();

        // Reset pulse during WIND with start held
        t0 = cyc;
        push(EV_IDLE, t0 + 2, 8'h00, 1'b0, 1'b1);
        bus.start = 1'b1; bus.decrypt = 1'b1; bus.take = 1'b1; phi_in = pa[0];
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.start = 1'b0; bus.decrypt = 1'b0; bus.take = 1'b0;
        repeat (3) tick();

        // Back-to-back: encrypt then decrypt started in the IDLE after FIN
        enc_run(1'b0, 1'b0, 1'b0);
        tick();
        dec_run(1'b1);
        repeat (3) tick();

        for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick();
        tick();
        tb_end = 1'b1;
    end

endmodule
